// File: rtl/axi4_lite_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the AXI4-Lite slave's read and write paths.
// Define AXI_MEM_TIMEOUT_EN to abandon accesses after TIMEOUT_CYCLES without mem_ready_i.
module axi4_lite_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic                  read_request_i,
  input  logic                  write_request_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  start_read_o,
  output logic                  start_write_o,
  output logic                  successful_access_o,
  output logic                  successful_read_o,
  output logic                  successful_write_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ready_i,
  input  logic                  mem_err_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e                state_q, state_d;
  logic                  prio_q, prio_d;         // 1 favours write on contention
  logic                  status_q, status_d;
  logic                  served_rd_q, served_rd_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

`ifdef AXI_MEM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout;
  assign timeout = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`endif

  assign mem_addr_o  = addr_i;
  assign mem_wdata_o = wdata_i;
  assign data_o      = data_q;

  always_comb begin
    state_d             = state_q;
    prio_d              = prio_q;
    status_d            = status_q;
    served_rd_d         = served_rd_q;
    data_d              = data_q;
    start_read_o        = 1'b0;
    start_write_o       = 1'b0;
    mem_req_o           = 1'b0;
    mem_we_o            = 1'b0;
    successful_access_o = 1'b0;
    successful_read_o   = 1'b0;
    successful_write_o  = 1'b0;
`ifdef AXI_MEM_TIMEOUT_EN
    cnt_d               = cnt_q;
`endif
    case (state_q)
      StIdle: begin
`ifdef AXI_MEM_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (read_request_i && (!write_request_i || !prio_q)) begin
          state_d     = StRead;
          prio_d      = 1'b1;
          served_rd_d = 1'b1;
        end else if (write_request_i) begin
          state_d     = StWrite;
          prio_d      = 1'b0;
          served_rd_d = 1'b0;
        end
      end
      StRead, StWrite: begin
        start_read_o  = (state_q == StRead);
        start_write_o = (state_q == StWrite);
        mem_req_o     = 1'b1;
        mem_we_o      = (state_q == StWrite);
        if (mem_ready_i) begin
          state_d  = StDone;
          status_d = !mem_err_i;
          if (state_q == StRead) data_d = mem_rdata_i;
        end
`ifdef AXI_MEM_TIMEOUT_EN
        else if (timeout) begin
          state_d  = StDone;
          status_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      StDone: begin
        successful_read_o   = served_rd_q;
        successful_write_o  = !served_rd_q;
        successful_access_o = status_q;
        state_d             = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q     <= StIdle;
      prio_q      <= 1'b0;
      status_q    <= 1'b0;
      served_rd_q <= 1'b0;
      data_q      <= '0;
`ifdef AXI_MEM_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      status_q    <= status_d;
      served_rd_q <= served_rd_d;
      data_q      <= data_d;
`ifdef AXI_MEM_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_axi4_lite_mem_arbiter.sv
// Self-checking bench for axi4_lite_mem_arbiter: directed scenarios plus randomized accesses
// checked against a transaction-level model (grant order, status, captured read data).
module tb_axi4_lite_mem_arbiter;

`ifdef AXI_MEM_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 16;
`endif

  logic        clk_i = 1'b0;
  logic        arst_ni = 1'b0;
  logic        read_request_i = 1'b0, write_request_i = 1'b0;
  logic [63:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        start_read_o, start_write_o, successful_access_o;
  logic        successful_read_o, successful_write_o;
  logic [31:0] data_o;
  logic        mem_req_o, mem_we_o;
  logic [63:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ready_i = 1'b0, mem_err_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  int tests = 0;
  int fails = 0;
  bit prio_m = 1'b0;
  logic [31:0] data_m = '0;

  always #5 clk_i = ~clk_i;

  axi4_lite_mem_arbiter #(
    .ADDR_WIDTH(64), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i), .arst_ni(arst_ni),
    .read_request_i(read_request_i), .write_request_i(write_request_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .start_read_o(start_read_o), .start_write_o(start_write_o),
    .successful_access_o(successful_access_o),
    .successful_read_o(successful_read_o), .successful_write_o(successful_write_o),
    .data_o(data_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ready_i(mem_ready_i), .mem_err_i(mem_err_i), .mem_rdata_i(mem_rdata_i)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " start_read"}, 64'(start_read_o), 64'd0);
    check({tag, " start_write"}, 64'(start_write_o), 64'd0);
    check({tag, " mem_req"}, 64'(mem_req_o), 64'd0);
    check({tag, " succ_read"}, 64'(successful_read_o), 64'd0);
    check({tag, " succ_write"}, 64'(successful_write_o), 64'd0);
  endtask

  // One complete access: the model decides which path wins and what data_o must hold afterwards.
  task automatic access(input bit r, input bit w, input logic [63:0] addr,
                        input logic [31:0] wd, input int waits, input bit err,
                        input logic [31:0] rd, input bit never_ready, input string tag);
    bit exp_rd;
    exp_rd = r && (!w || !prio_m);
    prio_m = exp_rd;
    read_request_i = r;
    write_request_i = w;
    addr_i = addr;
    wdata_i = wd;
    tick();
    check({tag, " grant_rd"}, 64'(start_read_o), 64'(exp_rd));
    check({tag, " grant_wr"}, 64'(start_write_o), 64'(!exp_rd));
    check({tag, " mem_req"}, 64'(mem_req_o), 64'd1);
    check({tag, " mem_we"}, 64'(mem_we_o), 64'(!exp_rd));
    check({tag, " mem_addr"}, mem_addr_o, addr);
    check({tag, " mem_wdata"}, 64'(mem_wdata_o), 64'(wd));
    read_request_i = 1'b0;
    write_request_i = 1'b0;
    for (int i = 0; i < waits; i++) begin
      tick();
      check({tag, " wait_grant"}, 64'({start_read_o, start_write_o, mem_req_o}),
            64'({exp_rd, !exp_rd, 1'b1}));
    end
    if (!never_ready) begin
      mem_ready_i = 1'b1;
      mem_err_i = err;
      mem_rdata_i = rd;
    end
    tick();
    mem_ready_i = 1'b0;
    mem_err_i = 1'b0;
    mem_rdata_i = $urandom;
    if (exp_rd && !never_ready) data_m = rd;
    check({tag, " done_rd"}, 64'(successful_read_o), 64'(exp_rd));
    check({tag, " done_wr"}, 64'(successful_write_o), 64'(!exp_rd));
    check({tag, " status"}, 64'(successful_access_o), 64'(!never_ready && !err));
    check({tag, " done_req"}, 64'({mem_req_o, start_read_o, start_write_o}), 64'd0);
    check({tag, " data"}, 64'(data_o), 64'(data_m));
    tick();
    check_quiet({tag, " idle"});
  endtask

  initial begin
    bit r, w;
    bit got;
    // Reset state
    read_request_i = 1'b1;
    write_request_i = 1'b1;
    mem_ready_i = 1'b1;
    tick();
    tick();
    check_quiet("reset");
    check("reset access", 64'(successful_access_o), 64'd0);
    check("reset data", 64'(data_o), 64'd0);
    check("reset we", 64'(mem_we_o), 64'd0);
    addr_i = 64'h1234_5678_9ABC_DEF0;
    #1;
    check("reset addr pass", mem_addr_o, 64'h1234_5678_9ABC_DEF0);

    // Both requests held from reset, zero-wait memory: R, W, R, W with period 3
    arst_ni = 1'b1;
    for (int k = 0; k < 12; k++) begin
      bit acc, rd_turn;
      tick();
      acc = (k % 3 == 0);
      rd_turn = ((k / 3) % 2 == 0);
      check("rr start_read", 64'(start_read_o), 64'(acc && rd_turn));
      check("rr start_write", 64'(start_write_o), 64'(acc && !rd_turn));
      check("rr succ_read", 64'(successful_read_o), 64'((k % 3 == 1) && rd_turn));
      check("rr succ_write", 64'(successful_write_o), 64'((k % 3 == 1) && !rd_turn));
      if (k == 11) begin
        read_request_i = 1'b0;
        write_request_i = 1'b0;
      end
    end
    mem_ready_i = 1'b0;
    prio_m = 1'b0;
    tick();
    check_quiet("rr drained");

    // Directed scenarios
    access(1, 0, 64'h100, 32'h0, 2, 0, 32'hDEADBEEF, 0, "read_2wait");
    access(0, 1, 64'h200, 32'h55AA00FF, 0, 1, 32'h0, 0, "write_err");
    access(1, 0, 64'h300, 32'h0, 0, 0, 32'hCAFEF00D, 0, "read_0wait");
    access(1, 0, 64'h304, 32'h0, 1, 1, 32'h0BADF00D, 0, "read_err");
`ifdef AXI_MEM_TIMEOUT_EN
    access(1, 0, 64'h400, 32'h0, TO - 1, 0, 32'h11111111, 1, "timeout");
    access(0, 1, 64'h404, 32'h1, TO - 1, 0, 32'h0, 0, "ready_last");
`endif

    // Reset during a write abandons it
    write_request_i = 1'b1;
    tick();
    check("rst_wr grant", 64'({start_write_o, mem_req_o}), 64'b11);
    write_request_i = 1'b0;
    #2;
    arst_ni = 1'b0;
    #1;
    check_quiet("rst_async");
    check("rst_async data", 64'(data_o), 64'd0);
    check("rst_async status", 64'(successful_access_o), 64'd0);
    data_m = '0;
    prio_m = 1'b1;  // read pending alone after release; grant must be read
    read_request_i = 1'b1;
    tick();
    check_quiet("rst_held");
    arst_ni = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 2 && !got; i++) begin
      tick();
      got = start_read_o;
    end
    check("rst_release read_grant", 64'(got), 64'd1);
    read_request_i = 1'b0;
    mem_ready_i = 1'b1;
    mem_rdata_i = 32'hA5A5_5A5A;
    tick();
    mem_ready_i = 1'b0;
    data_m = 32'hA5A5_5A5A;
    check("rst_release done", 64'({successful_read_o, successful_access_o}), 64'b11);
    check("rst_release data", 64'(data_o), 64'(data_m));
    tick();
    prio_m = 1'b1;

    // Randomized accesses against the model
    for (int n = 0; n < 40; n++) begin
      do begin
        r = 1'($urandom);
        w = 1'($urandom);
      end while (!r && !w);
      access(r, w, {$urandom, $urandom}, $urandom, int'($urandom_range(0, 2)),
             1'($urandom), $urandom, 0, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
